// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - opcode/size constants, bus FSM states and store lane formatting
// Purpose: shared definitions for the MEM-stage store path.
// Contents: store opcodes, bus size encodings, bus FSM state type,
//           lane-formatting result type and helper functions.
package store_unit_pkg;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } lane_fmt_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Replicate the store data across every lane it could land in, so the
    // memory only has to honour the strobe.
    function automatic lane_fmt_t format_store(input logic [5:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] wd);
        lane_fmt_t f;
        f.wdata = wd;
        f.wstrb = 4'b1111;
        f.size  = SIZE_W;
        case (op)
            OP_SB: begin
                f.wdata = {4{wd[7:0]}};
                f.wstrb = 4'b0001 << lo;
                f.size  = SIZE_B;
            end
            OP_SH: begin
                f.wdata = {2{wd[15:0]}};
                f.wstrb = lo[1] ? 4'b1100 : 4'b0011;
                f.size  = SIZE_H;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - synchronous store FIFO with count, full and empty flags
// Purpose: holds accepted stores until the bus drains them.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   i_push, i_data      write request and entry
//   i_pop               remove head entry
//   o_head              current head entry
//   o_count             number of valid entries (0..DEPTH)
//   o_full, o_empty     occupancy flags
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 70
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - MEM-stage store formatting, address check, store queue and bus drain
// Purpose: turns SB/SH/SW into lane-replicated data plus strobes, flags
//          misaligned stores, queues good stores and drains them over a
//          req/addr_ok/data_ok bus.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   memwriteM, opM, aluoutM,
//   writedataM, flushM               M-stage store request
//   adesM, badvaddrM                 store address error and faulting address
//   stall_storeM                     queue full with a live store in M
//   store_pending                    queue non-empty or bus busy
//   data_req .. data_wstrb           bus request fields
//   data_addr_ok, data_data_ok       bus handshake
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          memwriteM,
    input  logic [5:0]    opM,
    input  logic [AW-1:0] aluoutM,
    input  logic [31:0]   writedataM,
    input  logic          flushM,
    output logic          adesM,
    output logic [AW-1:0] badvaddrM,
    output logic          stall_storeM,
    output logic          store_pending,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [31:0]   data_wdata,
    output logic [3:0]    data_wstrb,
    input  logic          data_addr_ok,
    input  logic          data_data_ok
);
    localparam int EW = AW + 38;
    localparam int CW = $clog2(DEPTH) + 1;

    lane_fmt_t     w_fmt;
    logic          w_misaligned;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_bus;
    bus_state_t    r_state;
    bus_state_t    w_next;

    assign w_fmt        = format_store(opM, aluoutM[1:0], writedataM);
    assign w_misaligned = ((opM == OP_SH) & aluoutM[0]) |
                          ((opM == OP_SW) & (aluoutM[1:0] != 2'b00));

    assign adesM        = memwriteM & ~flushM & w_misaligned;
    assign badvaddrM    = adesM ? aluoutM : '0;
    assign stall_storeM = memwriteM & ~flushM & w_full;

    assign w_push = memwriteM & is_store(opM) & ~flushM & ~w_misaligned & ~w_full;
    assign w_pop  = (r_state == S_WAIT) & data_data_ok;

    store_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  ({aluoutM, w_fmt.wdata, w_fmt.wstrb, w_fmt.size}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // IDLE looks at the incoming push so a store into an empty queue is
    // requested on the very next cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!w_empty || w_push) w_next = S_REQ;
            S_REQ:  if (data_addr_ok)       w_next = S_WAIT;
            S_WAIT: if (data_data_ok)
                        w_next = ((w_count > CW'(1)) || w_push) ? S_REQ : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus fields come straight from the head; zero when nothing is queued
    // so reset leaves the bus quiet.
    assign w_bus = w_empty ? '0 : w_head;
    assign {data_addr, data_wdata, data_wstrb, data_size} = w_bus;

    assign data_req      = (r_state == S_REQ);
    assign data_wr       = 1'b1;
    assign store_pending = ~w_empty | (r_state != S_IDLE);

    // A write completion can only belong to the one outstanding transaction.
    a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!resetn)
        data_data_ok |-> (r_state == S_WAIT));

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit
module tb_store_unit;
    localparam int DEPTH = 2;
    localparam logic [5:0] SB = 6'b101000;
    localparam logic [5:0] SH = 6'b101001;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] LW = 6'b100011;

    logic        clk = 1'b0;
    logic        resetn;
    logic        memwriteM;
    logic [5:0]  opM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        adesM;
    logic [31:0] badvaddrM;
    logic        stall_storeM;
    logic        store_pending;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;

    always #5 clk = ~clk;

    store_unit #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .memwriteM     (memwriteM),
        .opM           (opM),
        .aluoutM       (aluoutM),
        .writedataM    (writedataM),
        .flushM        (flushM),
        .adesM         (adesM),
        .badvaddrM     (badvaddrM),
        .stall_storeM  (stall_storeM),
        .store_pending (store_pending),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } ent_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fl;
        logic        ades;
        logic        enq;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
    } vec_t;

    ent_t        q[$];
    bit          outstanding;
    logic [31:0] acc_addrs[$];
    logic        last_ades;
    logic        last_stall;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t expect_fmt(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] wd);
        ent_t e;
        e.addr = a;
        if (op == SB) begin
            e.wdata = {24'd0, wd[7:0]} * 32'h01010101;
            e.wstrb = 4'(1 << a[1:0]);
            e.size  = 2'd0;
        end else if (op == SH) begin
            e.wdata = {16'd0, wd[15:0]} * 32'h00010001;
            e.wstrb = 4'(3 << (32'(a[1]) * 2));
            e.size  = 2'd1;
        end else begin
            e.wdata = wd;
            e.wstrb = 4'hF;
            e.size  = 2'd2;
        end
        return e;
    endfunction

    function automatic bit misaligned(input logic [5:0] op, input logic [31:0] a);
        return (op == SH && (a % 2) != 0) || (op == SW && (a % 4) != 0);
    endfunction

    // Called right after a falling edge: drives one cycle of inputs, checks
    // the combinational outputs, advances the model across the rising edge
    // and checks registered outputs at the next falling edge.
    task automatic step(input logic mw, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic fl,
                        input logic aok, input logic dok);
        bit req_now, done, acc, push, mis, is_st;
        memwriteM    = mw;
        opM          = op;
        aluoutM      = a;
        writedataM   = wd;
        flushM       = fl;
        data_addr_ok = aok;
        data_data_ok = dok && outstanding;
        #1;
        is_st = (op == SB) || (op == SH) || (op == SW);
        mis   = misaligned(op, a);
        last_ades  = adesM;
        last_stall = stall_storeM;
        chk("adesM", adesM, mw && !fl && mis);
        chk("badvaddrM", badvaddrM, (mw && !fl && mis) ? a : 32'd0);
        chk("stall_storeM", stall_storeM, mw && !fl && q.size() == DEPTH);
        req_now = q.size() != 0 && !outstanding;
        done    = outstanding && dok;
        acc     = req_now && aok;
        push    = mw && is_st && !fl && !mis && q.size() < DEPTH;
        if (acc)  acc_addrs.push_back(data_addr);
        if (done) begin void'(q.pop_front()); outstanding = 0; end
        if (acc)  outstanding = 1;
        if (push) q.push_back(expect_fmt(op, a, wd));
        @(negedge clk);
        chk("data_req", data_req, q.size() != 0 && !outstanding);
        chk("store_pending", store_pending, q.size() != 0);
        chk("data_wr", data_wr, 1);
        if (q.size() != 0 && !outstanding) begin
            chk("data_addr", data_addr, q[0].addr);
            chk("data_wdata", data_wdata, q[0].wdata);
            chk("data_wstrb", data_wstrb, q[0].wstrb);
            chk("data_size", data_size, q[0].size);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) step(0, 0, 0, 0, 0, 1, 1);
        chk("drain bound", q.size(), 0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{SB, 32'h103, 32'h000000A5, 0, 0, 1, 32'hA5A5A5A5, 4'b1000, 2'd0};
        vecs[1]  = '{SH, 32'h102, 32'h1234BEEF, 0, 0, 1, 32'hBEEFBEEF, 4'b1100, 2'd1};
        vecs[2]  = '{SH, 32'h101, 32'h1234BEEF, 0, 1, 0, 32'h0, 4'b0, 2'd0};
        vecs[3]  = '{SW, 32'h000, 32'h11111111, 1, 0, 0, 32'h0, 4'b0, 2'd0};
        vecs[4]  = '{SW, 32'h006, 32'h22222222, 1, 0, 0, 32'h0, 4'b0, 2'd0};
        vecs[5]  = '{SW, 32'h006, 32'h22222222, 0, 1, 0, 32'h0, 4'b0, 2'd0};
        vecs[6]  = '{SB, 32'h100, 32'h12345678, 0, 0, 1, 32'h78787878, 4'b0001, 2'd0};
        vecs[7]  = '{SH, 32'h200, 32'hCAFE1234, 0, 0, 1, 32'h12341234, 4'b0011, 2'd1};
        vecs[8]  = '{SW, 32'h07C, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 4'b1111, 2'd2};
        vecs[9]  = '{SB, 32'h002, 32'h000000FF, 0, 0, 1, 32'hFFFFFFFF, 4'b0100, 2'd0};
        vecs[10] = '{SW, 32'h003, 32'h33333333, 0, 1, 0, 32'h0, 4'b0, 2'd0};
        vecs[11] = '{LW, 32'h001, 32'h44444444, 0, 0, 0, 32'h0, 4'b0, 2'd0};

        resetn = 0; memwriteM = 0; opM = 0; aluoutM = 0; writedataM = 0;
        flushM = 0; data_addr_ok = 0; data_data_ok = 0; outstanding = 0;
        repeat (2) @(negedge clk);
        chk("reset data_req", data_req, 0);
        chk("reset store_pending", store_pending, 0);
        chk("reset data_addr", data_addr, 0);
        chk("reset data_wr", data_wr, 1);
        resetn = 1;
        @(negedge clk);

        // Table vectors: one store, then drain it.
        foreach (vecs[i]) begin
            step(1, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].fl, 0, 0);
            chk("tbl ades", last_ades, vecs[i].ades);
            chk("tbl enq", data_req, vecs[i].enq);
            if (vecs[i].enq) begin
                chk("tbl addr", data_addr, vecs[i].addr);
                chk("tbl wdata", data_wdata, vecs[i].wdata);
                chk("tbl wstrb", data_wstrb, vecs[i].wstrb);
                chk("tbl size", data_size, vecs[i].size);
                step(0, 0, 0, 0, 0, 1, 0);
                step(0, 0, 0, 0, 0, 0, 1);
                chk("tbl pending after ok", store_pending, 0);
            end
            drain();
        end

        // Fill to full with addr_ok low, third store stalls until a pop.
        acc_addrs.delete();
        step(1, SW, 32'h0, 32'h11, 0, 0, 0);
        step(1, SW, 32'h4, 32'h22, 0, 0, 0);
        step(1, SW, 32'h8, 32'h33, 0, 0, 0);
        chk("full stall", last_stall, 1);
        step(1, SW, 32'h8, 32'h33, 0, 1, 0);
        chk("stall while waiting", last_stall, 1);
        step(1, SW, 32'h8, 32'h33, 0, 0, 1);
        chk("stall on pop cycle", last_stall, 1);
        step(1, SW, 32'h8, 32'h33, 0, 0, 0);
        chk("stall released", last_stall, 0);
        drain();
        chk("order count", acc_addrs.size(), 3);
        if (acc_addrs.size() == 3) begin
            chk("order 0", acc_addrs[0], 32'h0);
            chk("order 1", acc_addrs[1], 32'h4);
            chk("order 2", acc_addrs[2], 32'h8);
        end

        // Push in the same cycle as the pop of the only entry.
        step(1, SW, 32'h10, 32'h55, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, SW, 32'h20, 32'hAA, 0, 0, 1);
        chk("pp data_req", data_req, 1);
        chk("pp data_addr", data_addr, 32'h20);
        chk("pp data_wdata", data_wdata, 32'hAA);
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [5:0] rop;
            case ($urandom_range(0, 3))
                0: rop = SB;
                1: rop = SH;
                2: rop = SW;
                default: rop = LW;
            endcase
            step($urandom_range(0, 9) < 6, rop, $urandom & 32'h3FF, $urandom,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        drain();

        // Reset while WAIT with two entries queued.
        step(1, SW, 32'h30, 32'h77, 0, 0, 0);
        step(1, SW, 32'h34, 32'h88, 0, 1, 0);
        resetn = 0;
        #1;
        chk("rst data_req", data_req, 0);
        chk("rst store_pending", store_pending, 0);
        chk("rst data_addr", data_addr, 0);
        chk("rst data_wdata", data_wdata, 0);
        chk("rst data_wstrb", data_wstrb, 0);
        chk("rst data_size", data_size, 0);
        chk("rst data_wr", data_wr, 1);
        q.delete();
        outstanding = 0;
        memwriteM = 0; data_addr_ok = 0; data_data_ok = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
